alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Issue/writeback controller wrapped around the 4-bit low-power ALU (A, B, ALU_Sel -> ALU_Out).
- Holds a 4-entry x 4-bit operand register file and accepts one instruction per valid/ready handshake.
- Drives registered, isolated operands into the ALU, then captures ALU_Out back into the destination register.
- Operand registers load only on accept, so ALU inputs do not toggle while idle.

Parameters:
- DW, 4, datapath width; must match the ALU width.
- NREG, 4, number of architectural registers; x0 reads as zero.
- RW, 2, register index width, equal to clog2(NREG).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction valid.
- in_ready  output  1  controller can accept an instruction.
- in_op  input  3  ALU operation, same encoding as ALU_Sel.
- in_rd  input  RW  destination register.
- in_rs1  input  RW  source register for operand A.
- in_rs2  input  RW  source register for operand B.
- in_imm_sel  input  1  1 selects in_imm as operand B instead of rs2.
- in_imm  input  DW  immediate value.
- alu_a  output  DW  registered operand A to the ALU.
- alu_b  output  DW  registered operand B to the ALU.
- alu_sel  output  3  registered operation select to the ALU.
- alu_out  input  DW  ALU result, combinational from alu_a/alu_b/alu_sel.
- res_valid  output  1  one-cycle pulse when a result is written back.
- res_data  output  DW  written-back value, held until the next writeback.
- res_rd  output  RW  destination register of the last writeback.
- res_ovf  output  1  signed overflow of the last writeback (see Optional Feature).
- dbg_addr  input  RW  debug read index.
- dbg_data  output  DW  combinational read of the register file; x0 always reads 0.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. All registers are 0. alu_a, alu_b, alu_sel, res_valid, res_data, res_rd and res_ovf are 0. in_ready is 1 once rst_n is released.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready (cycle T):
    - alu_a <= rf[rs1].
    - alu_b <= in_imm_sel ? in_imm : rf[rs2].
    - alu_sel <= in_op; latch rd.
    - Next state is ISSUE.
  - ISSUE (T+1): in_ready=0. ALU output settles; no register writes. Next state is WB.
  - WB (T+2): in_ready=0.
    - Sample alu_out and write rf[rd] unless rd==0.
    - Set res_data=alu_out, res_rd=rd; pulse res_valid=1 for this cycle only.
    - Next state is IDLE.
- Throughput is one instruction per 3 cycles; the earliest next accept is at T+3.
- No hazards are possible: the register write at the end of T+2 precedes any read at T+3 or later.
- Operand isolation: alu_a, alu_b and alu_sel change only on an accept edge. In ISSUE, WB and IDLE they hold their last value.
- x0: reads return 0; writes are dropped. The result is still reported on res_* with res_rd=0.
- in_valid while in_ready=0: the instruction is not consumed. The source keeps it stable until accepted.
- Reset asserted in ISSUE or WB: the instruction is aborted, no writeback occurs, res_valid stays 0, and all state returns to reset values.
- All arithmetic wraps mod 2^DW; no carry out is kept.

Optional Feature:
- Macro: ALU_ISSUE_OVF_EN.
- Defined: at WB, res_ovf is the signed overflow of the result.
  - For op 000 (add): res_ovf = (a[3]==b[3]) && (r[3]!=a[3]).
  - For op 001 (subtract): res_ovf = (a[3]!=b[3]) && (r[3]!=a[3]).
  - For all other ops: res_ovf = 0.
  - res_ovf holds its value until the next WB.
- Not defined: res_ovf is tied to 0 and no overflow logic is built.

Decomposition:
- Package alu_issue_pkg:
  - DW, NREG, RW defaults.
  - Op constants: OP_ADD=000, OP_SUB=001, OP_ANDN=010, OP_SRL=011, OP_XOR=100, OP_SLL=101, OP_AND=110, OP_ROR=111.
  - FSM state enum: IDLE, ISSUE, WB.
- Sub-module alu_regfile: NREG x DW storage, 2 combinational read ports plus the debug port, 1 synchronous write port, async reset, x0 hardwired to zero.

Test Plan (bench instantiates alu_issue_ctrl connected to the ALU):
- Reset: after rst_n is released, in_ready=1, dbg_data=0 for all addresses, and all res_* outputs are 0.
- Load and arithmetic:
  - ADD rd=1, rs1=0, imm 1100 -> res_valid at T+2, res_data=1100, x1=1100.
  - ADD rd=2, rs1=0, imm 0010 -> x2=0010.
  - SUB rd=3, rs1=1, rs2=2 -> res_data=1010.
- Logic/shift with x1=1100, x2=0010: XOR -> 1110; AND(110) -> 0000; ANDN(010) -> 0010; SRL x1 -> 0110; ROR x1 -> 0110; SLL x1 -> 1000.
- x0 and backpressure:
  - ADD rd=0, imm 0101 -> res_valid=1, res_rd=0, dbg x0 still 0.
  - in_valid held high continuously -> accepts occur only every 3rd cycle; alu_a/alu_b are stable between accepts.
- Reset mid-op: assert rst_n=0 during ISSUE -> no res_valid pulse; dbg_data is 0 for all registers afterwards.
- Overflow: x1=0111, ADD imm 0001 -> res_data=1000, res_ovf=1 with ALU_ISSUE_OVF_EN and 0 without; SUB 1000 minus 0001 -> 0111, res_ovf=1.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
// Shared definitions for the ALU issue/writeback controller:
//   - datapath width, register count and index width
//   - ALU operation encodings (same encoding as the ALU's ALU_Sel)
//   - controller FSM state type
//   - signed-overflow helper used when ALU_ISSUE_OVF_EN is defined
package alu_issue_pkg;

    localparam int DW   = 4;
    localparam int NREG = 4;
    localparam int RW   = 2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ANDN = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_e;

    // Two's-complement overflow of add/subtract; all other ops never overflow.
    function automatic logic ovf_calc(input logic [2:0]    op,
                                      input logic [DW-1:0] a,
                                      input logic [DW-1:0] b,
                                      input logic [DW-1:0] r);
        logic ovf;
        ovf = 1'b0;
        case (op)
            OP_ADD:  ovf = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            OP_SUB:  ovf = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile
// NREG x DW operand register file with x0 hardwired to zero.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears all entries)
//   ra1_i / rd1_o         combinational read port 1
//   ra2_i / rd2_o         combinational read port 2
//   dbg_addr_i/dbg_data_o combinational debug read port
//   we_i, wa_i, wd_i      synchronous write port; writes to index 0 are dropped
module alu_regfile
    import alu_issue_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] ra1_i,
    output logic [DW-1:0] rd1_o,
    input  logic [RW-1:0] ra2_i,
    output logic [DW-1:0] rd2_o,
    input  logic [RW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o,
    input  logic          we_i,
    input  logic [RW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [DW-1:0] rf_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            rf_q[wa_i] <= wd_i;
        end
    end

    // Entry 0 is never written, but the read mux forces zero anyway so x0
    // stays zero regardless of what the storage cell holds.
    assign rd1_o      = (ra1_i      == '0) ? '0 : rf_q[ra1_i];
    assign rd2_o      = (ra2_i      == '0) ? '0 : rf_q[ra2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issue/writeback controller around a 4-bit combinational ALU.
// One instruction is accepted per valid/ready handshake, operands are
// registered into the ALU, and the ALU result is written back two cycles later.
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1; while in_ready is 0 the source holds the instruction
// stable and it is not consumed.
// Timeline for an accept at edge T: ISSUE during T+1, WB during T+2
// (res_valid=1, res_data/res_rd/res_ovf valid), register write at the end
// of T+2, next accept possible at T+3.
// Optional feature: define ALU_ISSUE_OVF_EN to build signed-overflow
// reporting on res_ovf; otherwise res_ovf is tied to 0.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               instruction handshake
//   in_op,in_rd,in_rs1,in_rs2       operation and register indices
//   in_imm_sel,in_imm               immediate select and value for operand B
//   alu_a,alu_b,alu_sel             registered, isolated ALU inputs
//   alu_out                         ALU result
//   res_valid,res_data,res_rd,res_ovf  writeback report
//   dbg_addr,dbg_data               debug register-file read
module alu_issue_ctrl
    import alu_issue_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [RW-1:0] in_rd,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic          in_imm_sel,
    input  logic [DW-1:0] in_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [RW-1:0] res_rd,
    output logic          res_ovf,
    input  logic [RW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_e        state_q, state_d;
    logic          accept;
    logic          capture;
    logic          rf_we;

    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [2:0]    alu_sel_q;
    logic [RW-1:0] rd_q;
    logic [DW-1:0] res_data_q;
    logic [RW-1:0] res_rd_q;

    logic [DW-1:0] rs1_data, rs2_data;

    alu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra1_i      (in_rs1),
        .rd1_o      (rs1_data),
        .ra2_i      (in_rs2),
        .rd2_o      (rs2_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (rf_we),
        .wa_i       (rd_q),
        .wd_i       (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // ALU settles during this cycle; the report is registered on
                // the edge into WB so it is visible alongside res_valid.
                capture = 1'b1;
                state_d = WB;
            end
            WB: begin
                rf_we   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand isolation: the ALU inputs only move on an accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            rd_q      <= '0;
        end else if (accept) begin
            alu_a_q   <= rs1_data;
            alu_b_q   <= in_imm_sel ? in_imm : rs2_data;
            alu_sel_q <= in_op;
            rd_q      <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else if (capture) begin
            res_data_q <= alu_out;
            res_rd_q   <= rd_q;
        end
    end

`ifdef ALU_ISSUE_OVF_EN
    logic res_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_ovf_q <= 1'b0;
        end else if (capture) begin
            res_ovf_q <= ovf_calc(alu_sel_q, alu_a_q, alu_b_q, alu_out);
        end
    end

    assign res_ovf = res_ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = (state_q == WB);
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Drives alu_issue_ctrl connected to a behavioural 4-bit ALU and checks every
// instruction against an architectural register-file model held in the bench.
module tb_alu_issue_ctrl;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] ANDN = 3'd2;
    localparam logic [2:0] SRL  = 3'd3;
    localparam logic [2:0] XOR  = 3'd4;
    localparam logic [2:0] SLL  = 3'd5;
    localparam logic [2:0] AND  = 3'd6;
    localparam logic [2:0] ROR  = 3'd7;

`ifdef ALU_ISSUE_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic       in_imm_sel;
    logic [3:0] in_imm;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       res_valid;
    logic [3:0] res_data;
    logic [1:0] res_rd;
    logic       res_ovf;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] ref_rf [4];
    logic [3:0] last_data;
    logic       last_ovf;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ALU behaviour ----------------
    function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            ANDN:    return ~a & b;
            SRL:     return a >> 1;
            XOR:     return a ^ b;
            SLL:     return a << 1;
            AND:     return a & b;
            default: return {a[0], a[3:1]};
        endcase
    endfunction

    // Signed overflow from integer arithmetic on the two's-complement values.
    function automatic logic ovf_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        if (op == ADD)      s = sa + sb;
        else if (op == SUB) s = sa - sb;
        else                return 1'b0;
        return OVF_ON && (s > 7 || s < -8);
    endfunction

    assign alu_out = alu_fn(alu_sel, alu_a, alu_b);

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_ovf    (res_ovf),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk(tag, {4'h0, dbg_data}, {4'h0, ref_rf[i]});
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; leaves the bench at the falling edge of T+3.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic isel, input logic [3:0] imm);
        logic [3:0] ea, eb, er;
        logic       eo;
        int         guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", {7'h0, in_ready}, 8'h1);
        ea = ref_rf[rs1];
        eb = isel ? imm : ref_rf[rs2];
        er = alu_fn(op, ea, eb);
        eo = ovf_fn(op, ea, eb);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm_sel = isel; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);                       // ISSUE
        in_valid = 1'b0;
        chk("issue_ready", {7'h0, in_ready}, 8'h0);
        chk("issue_valid", {7'h0, res_valid}, 8'h0);
        chk("issue_a", {4'h0, alu_a}, {4'h0, ea});
        chk("issue_b", {4'h0, alu_b}, {4'h0, eb});
        chk("issue_sel", {5'h0, alu_sel}, {5'h0, op});
        @(negedge clk);                       // WB
        chk("wb_valid", {7'h0, res_valid}, 8'h1);
        chk("wb_data", {4'h0, res_data}, {4'h0, er});
        chk("wb_rd", {6'h0, res_rd}, {6'h0, rd});
        chk("wb_ovf", {7'h0, res_ovf}, {7'h0, eo});
        last_data = res_data;
        last_ovf  = res_ovf;
        if (rd != 2'd0) ref_rf[rd] = er;
        @(negedge clk);                       // back in IDLE
        chk("post_valid", {7'h0, res_valid}, 8'h0);
        chk("post_ready", {7'h0, in_ready}, 8'h1);
        chk("post_hold", {4'h0, res_data}, {4'h0, er});
        dbg_addr = rd;
        #1;
        chk("post_rf", {4'h0, dbg_data}, {4'h0, ref_rf[rd]});
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int         accepts;
        int         last_acc;
        logic [3:0] ea, eb;

        rst_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm_sel = 1'b0; in_imm = '0; dbg_addr = '0;
        for (int i = 0; i < 4; i++) ref_rf[i] = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {7'h0, in_ready}, 8'h1);
        chk("rst_valid", {7'h0, res_valid}, 8'h0);
        chk("rst_data", {4'h0, res_data}, 8'h0);
        chk("rst_rd", {6'h0, res_rd}, 8'h0);
        chk("rst_ovf", {7'h0, res_ovf}, 8'h0);
        chk("rst_a", {4'h0, alu_a}, 8'h0);
        chk_rf_all("rst_rf");

        // Load and arithmetic
        issue(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'b1100);
        chk("dir_ld1", {4'h0, last_data}, 8'h0C);
        issue(ADD, 2'd2, 2'd0, 2'd0, 1'b1, 4'b0010);
        chk("dir_ld2", {4'h0, last_data}, 8'h02);
        issue(SUB, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0);
        chk("dir_sub", {4'h0, last_data}, 8'h0A);

        // Logic / shift
        issue(XOR,  2'd3, 2'd1, 2'd2, 1'b0, 4'h0); chk("dir_xor",  {4'h0, last_data}, 8'h0E);
        issue(AND,  2'd3, 2'd1, 2'd2, 1'b0, 4'h0); chk("dir_and",  {4'h0, last_data}, 8'h00);
        issue(ANDN, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0); chk("dir_andn", {4'h0, last_data}, 8'h02);
        issue(SRL,  2'd3, 2'd1, 2'd2, 1'b0, 4'h0); chk("dir_srl",  {4'h0, last_data}, 8'h06);
        issue(ROR,  2'd3, 2'd1, 2'd2, 1'b0, 4'h0); chk("dir_ror",  {4'h0, last_data}, 8'h06);
        issue(SLL,  2'd3, 2'd1, 2'd2, 1'b0, 4'h0); chk("dir_sll",  {4'h0, last_data}, 8'h08);

        // x0 write dropped but reported
        issue(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 4'b0101);
        chk("x0_data", {4'h0, last_data}, 8'h05);
        dbg_addr = 2'd0;
        #1;
        chk("x0_reads0", {4'h0, dbg_data}, 8'h00);

        // Backpressure: in_valid held high, accepts only every third cycle
        in_op = ADD; in_rd = 2'd1; in_rs1 = 2'd1; in_rs2 = 2'd0; in_imm_sel = 1'b1; in_imm = 4'h1;
        in_valid = 1'b1;
        accepts = 0; last_acc = 0; ea = '0; eb = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (in_ready) begin
                if (accepts > 0) chk("bp_gap", 8'(cyc - last_acc), 8'd3);
                accepts++;
                last_acc = cyc;
                ea = ref_rf[1];
                eb = 4'h1;
                ref_rf[1] = ea + eb;
            end else begin
                chk("bp_a_stable", {4'h0, alu_a}, {4'h0, ea});
                chk("bp_b_stable", {4'h0, alu_b}, {4'h0, eb});
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepts", 8'(accepts), 8'd4);
        chk_rf_all("bp_rf");

        // Reset during ISSUE aborts the instruction
        in_op = ADD; in_rd = 2'd2; in_rs1 = 2'd0; in_imm_sel = 1'b1; in_imm = 4'h5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_valid0", {7'h0, res_valid}, 8'h0);
        chk("abort_a", {4'h0, alu_a}, 8'h0);
        @(negedge clk);
        chk("abort_valid1", {7'h0, res_valid}, 8'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) ref_rf[i] = 4'h0;
        @(negedge clk);
        chk("abort_valid2", {7'h0, res_valid}, 8'h0);
        chk("abort_ready", {7'h0, in_ready}, 8'h1);
        chk("abort_data", {4'h0, res_data}, 8'h0);
        chk_rf_all("abort_rf");

        // Randomized instructions against the model
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        chk_rf_all("rand_rf");

        // Overflow
        issue(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'b0111);
        issue(ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'b0001);
        chk("ovf_add_data", {4'h0, last_data}, 8'h08);
        chk("ovf_add_flag", {7'h0, last_ovf}, {7'h0, OVF_ON});
        issue(SUB, 2'd3, 2'd2, 2'd0, 1'b1, 4'b0001);
        chk("ovf_sub_data", {4'h0, last_data}, 8'h07);
        chk("ovf_sub_flag", {7'h0, last_ovf}, {7'h0, OVF_ON});
        issue(XOR, 2'd3, 2'd2, 2'd1, 1'b0, 4'h0);
        chk("ovf_other", {7'h0, last_ovf}, 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
